// File: rtl/microsequencer_param.sv
// Parametrised microprogram sequencer: writable microcode store, MIR driving the
// control word, next-address select from incrementer/branch/decode/stack/loop counter.
//   state | meaning
//   IDLE  | stopped, microcode writes accepted, control word forced to zero
//   RUN   | one microinstruction per clock, writes ignored
module microsequencer_param #(
  parameter int CTL_W      = 32,
  parameter int AW         = 8,
  parameter int NUM_COND   = 4,
  parameter int STACK_D    = 4,
  parameter int CNT_W      = 8,
  parameter int RESET_ADDR = 0,
  localparam int CSW       = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
  localparam int MW        = CTL_W + AW + CSW + 5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [MW-1:0]       wdata_i,
  input  logic [AW-1:0]       entry_i,
  input  logic [NUM_COND-1:0] cond_in_i,
  output logic [CTL_W-1:0]    ctl_o,
  output logic [AW-1:0]       upc_o,
  output logic                running_o,
  output logic                stk_err_o
);

  localparam int SPW = $clog2(STACK_D + 1);

  localparam logic [3:0] OP_JUMP  = 4'd1;
  localparam logic [3:0] OP_CJMP  = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_WAIT  = 4'd4;
  localparam logic [3:0] OP_CALL  = 4'd5;
  localparam logic [3:0] OP_RET   = 4'd6;
  localparam logic [3:0] OP_LOOP  = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;
  localparam logic [3:0] OP_LDCNT = 4'd9;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [MW-1:0]    mem [0:(1<<AW)-1];
  logic [MW-1:0]    mir_q;
  logic [AW-1:0]    upc_q;
  logic             stk_err_q;
  logic [SPW-1:0]   sp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    stk_q [STACK_D];

  logic [AW-1:0]    next_f;
  logic [CSW-1:0]   csel_f;
  logic             inv_f;
  logic [3:0]       op_f;

  assign next_f = mir_q[CTL_W +: AW];
  assign csel_f = mir_q[CTL_W+AW +: CSW];
  assign inv_f  = mir_q[CTL_W+AW+CSW];
  assign op_f   = mir_q[CTL_W+AW+CSW+1 +: 4];

  logic             cond_raw;
  logic             c;
  logic [AW-1:0]    upc_inc;
  logic [AW-1:0]    stk_top;
  logic [AW-1:0]    na_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hold, halt, err, push, pop;

  assign upc_inc = upc_q + AW'(1);

  // Out-of-range selects leave cond_raw at 0
  always_comb begin
    cond_raw = 1'b0;
    for (int i = 0; i < NUM_COND; i++)
      if (csel_f == CSW'(i)) cond_raw = cond_in_i[i];
  end
  assign c = cond_raw ^ inv_f;

  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STACK_D; i++)
      if (SPW'(i + 1) == sp_q) stk_top = stk_q[i];
  end

  always_comb begin
    na_d  = upc_inc;
    cnt_d = cnt_q;
    hold  = 1'b0;
    halt  = 1'b0;
    err   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    case (op_f)
      OP_JUMP:  na_d = next_f;
      OP_CJMP:  if (c) na_d = next_f;
      OP_DEC:   na_d = entry_i;
      OP_WAIT:  hold = !c;
      OP_CALL:  if (sp_q == SPW'(STACK_D)) err = 1'b1;
                else begin push = 1'b1; na_d = next_f; end
      OP_RET:   if (sp_q == '0) err = 1'b1;
                else begin pop = 1'b1; na_d = stk_top; end
      OP_LOOP:  if (cnt_q != '0) begin cnt_d = cnt_q - CNT_W'(1); na_d = next_f; end
      OP_HALT:  halt = 1'b1;
      OP_LDCNT: cnt_d = CNT_W'(next_f);
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == IDLE && we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mir_q     <= '0;
      upc_q     <= AW'(RESET_ADDR);
      stk_err_q <= 1'b0;
      sp_q      <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE) begin
      // A write in the same cycle takes priority over START
      if (start_i && !we_i) begin
        state_q   <= RUN;
        upc_q     <= AW'(RESET_ADDR);
        mir_q     <= mem[AW'(RESET_ADDR)];
        stk_err_q <= 1'b0;
        sp_q      <= '0;
        cnt_q     <= '0;
      end
    end else begin
      if (halt) begin
        state_q <= IDLE;
        mir_q   <= '0;
      end else if (err) begin
        stk_err_q <= 1'b1;
        state_q   <= IDLE;
        mir_q     <= '0;
      end else if (!hold) begin
        upc_q <= na_d;
        mir_q <= mem[na_d];
        cnt_q <= cnt_d;
        if (push) begin
          for (int i = 0; i < STACK_D; i++)
            if (SPW'(i) == sp_q) stk_q[i] <= upc_inc;
          sp_q <= sp_q + SPW'(1);
        end
        if (pop) sp_q <= sp_q - SPW'(1);
      end
    end
  end

  assign ctl_o     = mir_q[CTL_W-1:0];
  assign upc_o     = upc_q;
  assign running_o = (state_q == RUN);
  assign stk_err_o = stk_err_q;

endmodule
